// File: rtl/ncs_pkg.sv
// Shared types for the noise-cancellation sample path: slot width, transmitter
// state encoding and the {iir, lms} sample pair carried through the output FIFO.
package ncs_pkg;

    localparam int NCS_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [NCS_DATA_W-1:0] iir;
        logic [NCS_DATA_W-1:0] lms;
    } pair_t;

endpackage

// File: rtl/ncs_pair_fifo.sv
// Two-entry synchronous FIFO with registered occupancy; read data is the head entry.
// Zero-latency read of the head; push is ignored when full and pop ignored when empty.
module ncs_pair_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop  && (count != 2'd0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ncs_sample_tx.sv
// Serialises buffered {iir, lms} pairs MSB-first onto an sclk/lrclk/sdata frame.
// First bit one clk after a push into an idle empty FIFO; in_ready drops when the FIFO holds two pairs.
module ncs_sample_tx
    import ncs_pkg::*;
#(
    parameter int DATA_W  = NCS_DATA_W,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] iir_data,
    input  logic [DATA_W-1:0] lms_data,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              busy,
    output logic              tx_done
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [DIV_W-1:0]   div_q;
    logic [BIT_W-1:0]   bit_q;
    logic [FRAME_W-1:0] shreg;
    logic               ready_en;
    logic               tx_done_q;

    logic [FRAME_W-1:0] fifo_dat;
    logic [1:0]         fifo_count;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               bit_end;
    logic               left_end;
    logic               frame_end;

    // ready_en keeps in_ready low until the first clk edge after reset release
    assign in_ready   = ready_en && (fifo_count != 2'd2);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_count == 2'd0);

    assign bit_end   = (state != IDLE) && (div_q == DIV_W'(2 * CLK_DIV - 1));
    assign left_end  = bit_end && (bit_q == BIT_W'(DATA_W - 1));
    assign frame_end = bit_end && (bit_q == BIT_W'(FRAME_W - 1));
    assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

    ncs_pair_fifo #(
        .W (FRAME_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({iir_data, lms_data}),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = SHIFT_L;
            end
            SHIFT_L: begin
                if (left_end) state_nxt = SHIFT_R;
            end
            SHIFT_R: begin
                if (frame_end) state_nxt = fifo_empty ? IDLE : SHIFT_L;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sclk  = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        busy  = 1'b0;
        case (state)
            SHIFT_L: begin
                busy  = 1'b1;
                sclk  = (div_q >= DIV_W'(CLK_DIV));
                sdata = shreg[FRAME_W-1];
            end
            SHIFT_R: begin
                busy  = 1'b1;
                lrclk = 1'b1;
                sclk  = (div_q >= DIV_W'(CLK_DIV));
                sdata = shreg[FRAME_W-1];
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // a pop always restarts the bit timing, so frames chain with no gap bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            bit_q <= '0;
            shreg <= '0;
        end else if (pop) begin
            div_q <= '0;
            bit_q <= '0;
            shreg <= fifo_dat;
        end else if (state != IDLE) begin
            if (bit_end) begin
                div_q <= '0;
                bit_q <= bit_q + BIT_W'(1);
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end else begin
            div_q <= '0;
            bit_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_done_q <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            tx_done_q <= frame_end;
            ready_en  <= 1'b1;
        end
    end

    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_ncs_sample_tx.sv
// Bench for ncs_sample_tx: directed vector table, multi-cycle corner sequences and
// random traffic scored against a queue of accepted pairs decoded from the serial link.
module tb_ncs_sample_tx;
    import ncs_pkg::*;

    localparam int DW    = NCS_DATA_W;
    localparam int CD    = 2;
    localparam int FRAME = 2 * DW * 2 * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] iir_data = '0;
    logic [DW-1:0] lms_data = '0;
    logic          in_ready, sclk, lrclk, sdata, busy, tx_done;

    always #5 clk = ~clk;

    ncs_sample_tx #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .iir_data (iir_data),
        .lms_data (lms_data),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    int total = 0;
    int bad   = 0;

    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] cur = '0;
    logic [2*DW-1:0] last_frame = '0;
    int   nbits = 0, lo_run = 0, hi_run = 0, timing_err = 0;
    int   tx_cnt = 0, frames = 0, cyc = 0, start_cyc = 0;
    logic prev_sclk = 0, prev_sdata = 0, prev_lr = 0, prev_busy = 0, prev_txd = 0;
    logic lr_ok = 1'b1;

    // Link decoder: one bit per sclk rise; each completed 32-bit frame is scored.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            nbits = 0; lo_run = 0; hi_run = 0; lr_ok = 1'b1;
            prev_sclk = 0; prev_busy = 0; prev_txd = 0;
            exp_q.delete();
        end else begin
            if (sclk && !prev_sclk) begin
                if (lo_run != CD) timing_err++;
                hi_run = 1;
                cur = {cur[2*DW-2:0], sdata};
                if (lrclk != (nbits >= DW)) lr_ok = 1'b0;
                nbits++;
                if (nbits == 2*DW) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_unexpected got=%h required=none", cur);
                    end else begin
                        logic [2*DW-1:0] e;
                        e = exp_q.pop_front();
                        if (cur !== e || !lr_ok) begin
                            bad++;
                            $display("FAIL frame got=%h lr_ok=%0d required=%h lr_ok=1", cur, lr_ok, e);
                        end
                    end
                    last_frame = cur;
                    frames++;
                    nbits = 0;
                    lr_ok = 1'b1;
                end
            end else if (sclk) begin
                hi_run++;
                if (sdata != prev_sdata || lrclk != prev_lr) timing_err++;
            end else if (prev_sclk) begin
                if (hi_run != CD) timing_err++;
                lo_run = busy ? 1 : 0;
            end else begin
                lo_run = busy ? lo_run + 1 : 0;
            end
            if (tx_done) begin
                tx_cnt++;
                if (prev_txd) timing_err++;
                total++;
                if (cyc - start_cyc != FRAME) begin
                    bad++;
                    $display("FAIL frame_len got=%0d required=%0d", cyc - start_cyc, FRAME);
                end
                start_cyc = cyc;
            end
            if (busy && !prev_busy) start_cyc = cyc;
            if (in_valid && in_ready) exp_q.push_back({iir_data, lms_data});
            prev_sclk = sclk; prev_sdata = sdata; prev_lr = lrclk;
            prev_busy = busy; prev_txd = tx_done;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] i, input logic [DW-1:0] l, output bit ok);
        in_valid = 1'b1;
        iir_data = i;
        lms_data = l;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        pair_t           in;
        logic [2*DW-1:0] exp_bits;
    } vec_t;

    vec_t vecs[4];

    initial begin
        bit ok, ok2, ok3, drop;
        int t0, f0, seen, gap, busy_cnt;
        logic [DW-1:0] ri, rl;

        vecs[0] = '{'{16'h1234, 16'h5678}, 32'b0001001000110100_0101011001111000};
        vecs[1] = '{'{16'hFFFF, 16'h0000}, 32'b1111111111111111_0000000000000000};
        vecs[2] = '{'{16'h0001, 16'h8000}, 32'b0000000000000001_1000000000000000};
        vecs[3] = '{'{16'hA5C3, 16'h3C5A}, 32'b1010010111000011_0011110001011010};

        // Reset held with in_valid high
        rst = 1'b0;
        in_valid = 1'b1;
        iir_data = 16'hAAAA;
        lms_data = 16'h5555;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_outs", {26'd0, in_ready, sclk, lrclk, sdata, busy, tx_done}, 0);
        end
        rst = 1'b1;
        chk("ready_before_first_clk", {31'd0, in_ready}, 0);
        tick();
        chk("ready_after_release", {31'd0, in_ready}, 1);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("idle_after_release", {28'd0, sclk, lrclk, busy, tx_done}, 0);

        // Single frames from the vector table
        for (int v = 0; v < 4; v++) begin
            t0 = tx_cnt;
            push(vecs[v].in.iir, vecs[v].in.lms, ok);
            chk("push_ok", {31'd0, ok}, 1);
            chk("idle_on_push_edge", {30'd0, busy, sclk}, 0);
            tick();
            chk("first_bit", {29'd0, busy, lrclk, sdata}, {29'd0, 1'b1, 1'b0, vecs[v].exp_bits[2*DW-1]});
            for (int k = 0; k < FRAME + 20 && tx_cnt == t0; k++) tick();
            chk("tx_done_count", 32'(tx_cnt - t0), 1);
            repeat (6) tick();
            chk("frame_bits", last_frame, vecs[v].exp_bits);
            chk("idle_after_frame", {28'd0, busy, sclk, lrclk, sdata}, 0);
        end

        // Back-to-back: three consecutive pushes fill the FIFO while frame 1 runs
        t0 = tx_cnt; f0 = frames;
        push(16'h1234, 16'h5678, ok);
        push(16'h9ABC, 16'hDEF0, ok2);
        push(16'h0001, 16'h8000, ok3);
        chk("b2b_pushes", {29'd0, ok, ok2, ok3}, 32'h7);
        chk("b2b_full", {31'd0, in_ready}, 0);
        seen = 0; gap = 0;
        for (int k = 0; k < 3*FRAME + 50 && seen < 3; k++) begin
            tick();
            if (tx_done) seen++;
            if (seen < 3 && !busy) gap++;
        end
        chk("b2b_done_pulses", 32'(seen), 3);
        chk("b2b_gap", 32'(gap), 0);
        chk("b2b_last_frame", last_frame, 32'b0000000000000001_1000000000000000);
        repeat (6) tick();
        chk("b2b_frames", 32'(frames - f0), 3);
        chk("b2b_tx_cnt", 32'(tx_cnt - t0), 3);

        // Push lands on the frame-end edge while one entry is queued
        t0 = tx_cnt; f0 = frames; drop = 1'b0;
        push(16'h1111, 16'h2222, ok);
        push(16'h3333, 16'h4444, ok2);
        for (int k = 0; k < 127; k++) begin
            tick();
            if (!in_ready) drop = 1'b1;
        end
        in_valid = 1'b1;
        iir_data = 16'h5555;
        lms_data = 16'h6666;
        if (!in_ready) drop = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pop_push_done_edge", {31'd0, tx_done}, 1);
        for (int k = 0; k < 3*FRAME && (tx_cnt - t0) < 3; k++) begin
            if (!in_ready) drop = 1'b1;
            tick();
        end
        chk("pop_push_ready_held", {31'd0, drop}, 0);
        repeat (6) tick();
        chk("pop_push_frames", 32'(frames - f0), 3);

        // Asynchronous reset during bit 10 of the left slot, one entry queued
        t0 = tx_cnt; f0 = frames;
        push(16'hC0DE, 16'hBEEF, ok);
        push(16'hDEAD, 16'hF00D, ok2);
        repeat (41) tick();
        chk("busy_before_reset", {31'd0, busy}, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_reset_outs", {26'd0, in_ready, sclk, lrclk, sdata, busy, tx_done}, 0);
        repeat (3) tick();
        rst = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 3*FRAME; k++) begin
            tick();
            if (busy || sclk) busy_cnt++;
        end
        chk("no_stale_activity", 32'(busy_cnt), 0);
        chk("no_stale_done", 32'(tx_cnt - t0), 0);
        chk("no_stale_frame", 32'(frames - f0), 0);
        chk("ready_after_reset", {31'd0, in_ready}, 1);

        // Random traffic with random idle gaps
        f0 = frames;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(100, 300)) tick();
            else repeat ($urandom_range(0, 5)) tick();
            ri = DW'($urandom);
            rl = DW'($urandom);
            push(ri, rl, ok);
            chk("rand_push_ok", {31'd0, ok}, 1);
        end
        for (int k = 0; k < 4000 && (exp_q.size() != 0 || busy); k++) tick();
        chk("rand_frames", 32'(frames - f0), 24);
        chk("rand_queue_drained", 32'(exp_q.size()), 0);

        chk("bit_timing", 32'(timing_err), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
